ps_tx_scheduler: RTL
====================

Name: ps_tx_scheduler

Overview:
- Transmit-side scheduler for the 10-bit parallel-to-serial emitter.
- Shares one serializer among NUM_REQ word sources using round-robin arbitration at word boundaries.
- Holds each granted word stable on the serializer input for exactly WORD_W clock cycles.
- Inserts IDLE_SYMBOL when no source is eligible, so the serial line always carries a valid symbol for the receiver.

Parameters:
- NUM_REQ, 4, number of requesters sharing the serializer (2..8).
- WORD_W, 10, symbol width in bits; also the number of clk cycles per word.
- IDLE_SYMBOL, 10'b0011111010, filler word sent when no grant is issued (K28.5, RD-).
- CNT_W, 4, width of the bit-slot counter; must satisfy 2**CNT_W >= WORD_W.
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, same clock that drives the serializer.
- reset  in  1  asynchronous, active-high reset.
- tx_en  in  1  1 = arbitrate requesters; 0 = force idle words at every boundary.
- req_valid  in  NUM_REQ  per-requester word-available flag.
- req_data  in  NUM_REQ*WORD_W  requester words; requester i occupies bits [i*WORD_W +: WORD_W].
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- ps_data  out  WORD_W  registered word driven into the serializer's parallel input.
- ps_load  out  1  registered; high during the first cycle of each new word.
- grant_id  out  ID_W  registered index of the requester whose word is in ps_data.
- idle_flag  out  1  registered; 1 when ps_data holds IDLE_SYMBOL.
- slot_cnt  out  CNT_W  current bit-slot index, 0..WORD_W-1.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word):
  - slot_cnt=0, ps_data=IDLE_SYMBOL, ps_load=0, grant_id=0, idle_flag=1.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while reset is high.
- Slot counter:
  - Increments every clk.
  - Wraps from WORD_W-1 to 0.
  - The boundary cycle is the cycle with slot_cnt==WORD_W-1.
- Arbitration (combinational, boundary cycle only):
  - Condition: tx_en=1.
  - Search order: last+1, last+2, …, wrapping modulo NUM_REQ.
  - The first requester i with req_valid[i]=1 wins, and req_ready[i]=1.
  - Outside the boundary cycle, or when tx_en=0, req_ready is all zeros.
  - A transfer occurs when req_valid[i] & req_ready[i] at the rising edge.
  - Requesters must hold req_data stable while req_valid=1. A requester may deassert valid at any time without penalty.
- At the boundary edge, with a winner i:
  - ps_data <= req_data[i]; grant_id <= i; idle_flag <= 0; last <= i.
- At the boundary edge, with no winner:
  - ps_data <= IDLE_SYMBOL; idle_flag <= 1; grant_id and last are unchanged.
- ps_load:
  - Goes to 1 on every boundary edge, whether the word is data or idle.
  - Returns to 0 on the following edge.
  - Therefore ps_load=1 exactly when slot_cnt==0, except during the first word after reset.
- Stability: ps_data, grant_id and idle_flag change only on boundary edges, i.e. they are constant for WORD_W cycles.
- Latency: a word accepted at the boundary edge appears on ps_data in the next cycle (slot 0). Its first serial bit leaves the serializer in that same word period.
- Fairness: a requester holding req_valid=1 is granted within NUM_REQ boundaries.
- Simultaneous requests: exactly one grant per boundary; never more than one req_ready bit high.
- tx_en changes:
  - tx_en is sampled only in the boundary cycle.
  - Deasserting it mid-word does not truncate the current word.
  - The next word is IDLE_SYMBOL.
- Single requester: if only one requester is valid, it wins every boundary. Back-to-back words are sent with no idle gap.
- Reset released mid-stream: the counter restarts at 0, and the first boundary occurs WORD_W cycles after release.
- Out-of-range index: any req_data slice above NUM_REQ is never selected.

Test Plan:
1. Reset, then tx_en=1 with all valid=0 for 5 words → ps_data=10'b0011111010 throughout; idle_flag=1; ps_load pulses every 10 cycles starting at cycle 10; req_ready never set.
2. Only req 2 valid, data 10'b1010010101 → req_ready[2] high only in the slot-9 cycle; ps_data=10'b1010010101 from the next cycle for 10 cycles; grant_id=2; idle_flag=0.
3. All 4 valid continuously, data 10'h0AA/0x155/0x3E0/0x01F → grants in order 0,1,2,3,0,1…; each word held exactly 10 cycles; never two req_ready bits set.
4. Only req 1 and req 3 valid, last=1 → next grant 3, then 1, then 3 (pointer rotates past 2); no idle words inserted.
5. tx_en dropped at slot 4 while req 0 is valid → current word completes unchanged; next word is IDLE_SYMBOL with req_ready[0]=0; raising tx_en resumes grants at the next boundary.
6. Assert reset at slot 6 of a data word → all outputs go to reset values immediately (ps_data=IDLE_SYMBOL, slot_cnt=0, req_ready=0). After release, the first ps_load occurs exactly 10 clks later; serialParalelo recovers the subsequent data words bit-exact in a loopback.

Source files
------------

// File: rtl/ps_tx_scheduler.sv
// ps_tx_scheduler: round-robin word scheduler feeding a shared WORD_W-bit serializer
// Ports: clk, reset (async, active-high); tx_en gates arbitration; req_valid/req_data per requester;
// req_ready one-hot accept strobe (comb); ps_data/ps_load/grant_id/idle_flag registered word outputs;
// slot_cnt bit-slot index within the current word.
module ps_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W = 10,
  parameter logic [WORD_W-1:0] IDLE_SYMBOL = 10'b0011111010,
  parameter int CNT_W = 4,
  parameter int ID_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]         ps_data,
  output logic                      ps_load,
  output logic [ID_W-1:0]           grant_id,
  output logic                      idle_flag,
  output logic [CNT_W-1:0]          slot_cnt
);
  logic [CNT_W-1:0]  r_slot;
  logic [WORD_W-1:0] r_data;
  logic              r_load;
  logic [ID_W-1:0]   r_gid;
  logic [ID_W-1:0]   r_last;
  logic              r_idle;
  logic              w_boundary;
  logic              w_found;
  logic              w_go;
  logic [ID_W-1:0]   w_win;
  logic [ID_W:0]     w_idx;
  logic [WORD_W-1:0] w_word;
  assign w_boundary = r_slot == CNT_W'(WORD_W - 1);
  assign w_go = tx_en & w_found;
  // Search starts one past the last winner; the extra index bit absorbs the wrap before the modulo fold.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + (ID_W+1)'(k);
      w_idx = (w_idx >= (ID_W+1)'(NUM_REQ)) ? w_idx - (ID_W+1)'(NUM_REQ) : w_idx;
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end
    end
  end
  // Only slices below NUM_REQ are reachable, so unused upper slices can never be selected.
  always_comb begin
    w_word = IDLE_SYMBOL;
    for (int i = 0; i < NUM_REQ; i++)
      w_word = (w_win == ID_W'(i)) ? req_data[i*WORD_W +: WORD_W] : w_word;
  end
  assign req_ready = (w_boundary && w_go && !reset) ? NUM_REQ'(1) << w_win : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_slot <= '0;
      r_data <= IDLE_SYMBOL;
      r_load <= 1'b0;
      r_gid  <= '0;
      r_last <= ID_W'(NUM_REQ - 1);
      r_idle <= 1'b1;
    end else begin
      r_slot <= w_boundary ? '0 : r_slot + CNT_W'(1);
      r_load <= w_boundary;
      if (w_boundary) begin
        r_data <= w_go ? w_word : IDLE_SYMBOL;
        r_idle <= !w_go;
        if (w_go) begin
          r_gid  <= w_win;
          r_last <= w_win;
        end
      end
    end
  assign ps_data = r_data;
  assign ps_load = r_load;
  assign grant_id = r_gid;
  assign idle_flag = r_idle;
  assign slot_cnt = r_slot;
endmodule
